// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Imported by the loader top and its byte/word assembler.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } loader_state_e;

endpackage

// File: rtl/imem_boot_loader_assembler.sv
// Little-endian byte-to-word assembler for the boot loader.
// Pulses word_valid_o on the transfer that completes a word.
module byte_word_assembler
  import imem_loader_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  output logic [DataWidth-1:0] word_o,
  output logic                 word_valid_o
);

  localparam logic [1:0] LastByte = 2'(BYTES_PER_WORD - 1);

  logic [1:0]           cnt_q, cnt_d;
  logic [DataWidth-1:0] word_q, word_d;

  // Place each byte at its lane; word_o already includes the current byte.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clr_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (byte_valid_i) begin
      word_d[{cnt_q, 3'b000} +: 8] = byte_i;
      cnt_d = cnt_q + 2'd1;
    end
  end

  assign word_o       = word_d;
  assign word_valid_o = byte_valid_i & ~clr_i & (cnt_q == LastByte);

  // Byte-lane counter and partial word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Frame-driven imem loader: header, data words, checksum.
// Keeps the core in reset until a verified load completes.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int AddressWidth = 10,
  parameter int DataWidth    = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [7:0]              rx_data_i,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o,
  output logic                    imem_ld_o,
  output logic [AddressWidth-1:0] imem_ld_addr_o,
  output logic [DataWidth-1:0]    imem_ld_data_o,
  output logic                    core_rst_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int IdxW = AddressWidth + 1;
  localparam logic [LEN_W-1:0] MaxLen =
    LEN_W'(2 ** AddressWidth);

  loader_state_e state_q, state_d;

  logic [LEN_W-1:0]        len_q, len_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [IdxW-1:0]         idx_nxt;
  logic [7:0]              sum_q, sum_d;
  logic [7:0]              csum_tot;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0]    data_q, data_d;
  logic [LEN_W-1:0]        len_full;

  logic                    xfer;
  logic                    asm_vld;
  logic                    asm_clr;
  logic [DataWidth-1:0]    asm_word;
  logic                    asm_wvld;

  assign rx_ready_o = (state_q == S_LEN0) |
                      (state_q == S_LEN1) |
                      (state_q == S_DATA) |
                      (state_q == S_CSUM);

  assign xfer     = rx_valid_i & rx_ready_o;
  assign asm_vld  = xfer & (state_q == S_DATA);
  assign idx_nxt  = idx_q + 1'b1;
  assign len_full = {rx_data_i, len_q[7:0]};
  assign csum_tot = sum_q + rx_data_i;

  byte_word_assembler #(
    .DataWidth(DataWidth)
  ) u_asm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (asm_clr),
    .byte_valid_i(asm_vld),
    .byte_i      (rx_data_i),
    .word_o      (asm_word),
    .word_valid_o(asm_wvld)
  );

  // Next-state, counters, checksum and write-port capture.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    data_d  = data_q;
    asm_clr = 1'b0;
    unique case (state_q)
      S_LEN0: begin
        if (xfer) begin
          len_d[7:0] = rx_data_i;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d = len_full;
          if (len_full > MaxLen) begin
            state_d = S_ERR;
          end else if (len_full == '0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          sum_d = csum_tot;
          if (asm_wvld) begin
            addr_d  = idx_q[AddressWidth-1:0];
            data_d  = asm_word;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_nxt;
        if (LEN_W'(idx_nxt) == len_q) begin
          state_d = S_CSUM;
        end else begin
          state_d = S_DATA;
        end
      end
      S_CSUM: begin
        if (xfer) begin
          if (csum_tot == 8'h00) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_LEN0;
          len_d   = '0;
          idx_d   = '0;
          sum_d   = '0;
          asm_clr = 1'b1;
        end
      end
      default: begin
        state_d = S_LEN0;
      end
    endcase
  end

  // Loader state and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_LEN0;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign imem_ld_o      = (state_q == S_WRITE);
  assign imem_ld_addr_o = addr_q;
  assign imem_ld_data_o = data_q;

  assign done_o = (state_q == S_DONE);
  assign err_o  = (state_q == S_ERR);
  assign busy_o = ~(done_o | err_o);

  // A re-arm pulse puts the core back into reset in the same cycle.
  assign core_rst_o = ~(done_o & ~start_i);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader.
// Driver queues expected writes; a monitor checks each strobe.
module tb_imem_boot_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          ld;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          core_rst;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  bit gaps = 1'b0;

  logic [AW+31:0] exp_q[$];
  logic [31:0]    prog[$];

  always #5 clk = ~clk;

  imem_boot_loader #(
    .AddressWidth(AW),
    .DataWidth(32)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .rx_data_i     (rx_data),
    .rx_valid_i    (rx_valid),
    .rx_ready_o    (rx_ready),
    .imem_ld_o     (ld),
    .imem_ld_addr_o(ld_addr),
    .imem_ld_data_o(ld_data),
    .core_rst_o    (core_rst),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  logic prev_ld = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ld <= 1'b0;
    end else begin
      if (prev_ld) begin
        chk("strobe_one_cycle", {31'd0, ld}, 32'd0);
        chk("ready_after_write", {31'd0, rx_ready}, 32'd1);
      end
      if (ld) begin
        chk("ready_in_write", {31'd0, rx_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h",
                   ld_addr, ld_data);
        end else begin
          logic [AW+31:0] e;
          e = exp_q.pop_front();
          chk("ld_addr", {22'd0, ld_addr}, {22'd0, e[AW+31:32]});
          chk("ld_data", ld_data, e[31:0]);
        end
      end
      prev_ld <= ld;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: got 0 want 1");
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_status(input string tag, input bit ok);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, ok});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, !ok});
    chk({tag, "_core_rst"}, {31'd0, core_rst}, {31'd0, !ok});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ready"}, {31'd0, rx_ready}, 32'd0);
    chk({tag, "_writes"}, exp_q.size(), 32'd0);
  endtask

  // csum < 0 selects the value that satisfies the checksum rule.
  task automatic load(input string tag,
                      input logic [15:0] n,
                      input int csum);
    logic [7:0]  sum;
    logic [7:0]  cs;
    logic [31:0] w;
    bit          ovf;
    bit          ok;
    sum = 8'h00;
    ovf = (int'(n) > (1 << AW));
    while (prog.size() < int'(n)) prog.push_back($urandom);
    if (!ovf) begin
      for (int i = 0; i < int'(n); i++) begin
        w = prog[i];
        exp_q.push_back({AW'(i), w});
        sum = sum + w[7:0] + w[15:8] + w[23:16] + w[31:24];
      end
    end
    cs = (csum < 0) ? 8'(-sum) : 8'(csum);
    ok = !ovf && ((sum + cs) == 8'h00);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    if (ovf) begin
      chk({tag, "_err_after_hdr"}, {31'd0, err}, 32'd1);
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        w = prog[i];
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
      end
      send_byte(cs);
    end
    idle(2);
    check_status(tag, ok);
    prog.delete();
  endtask

  task automatic rearm(input string tag);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_core_rst"}, {31'd0, core_rst}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_ready"}, {31'd0, rx_ready}, 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_core_rst"}, {31'd0, core_rst}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_ready"}, {31'd0, rx_ready}, 32'd1);
    chk({tag, "_ld"}, {31'd0, ld}, 32'd0);
    chk({tag, "_addr"}, {22'd0, ld_addr}, 32'd0);
    chk({tag, "_data"}, ld_data, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    #12;
    check_reset("reset");
    rst_n = 1'b1;
    idle(2);
    check_reset("idle_after_reset");

    prog.push_back(32'h00500093);
    prog.push_back(32'h00A00113);
    load("frame_ok", 16'd2, -1);
    rearm("start_from_done");

    prog.push_back(32'h00500093);
    prog.push_back(32'h00A00113);
    load("frame_bad_csum", 16'd2, 0);
    rearm("start_from_err");

    load("len_too_big", 16'h0401, 0);
    rearm("rearm_big");
    load("len0_ok", 16'd0, 0);
    rearm("rearm_len0");
    load("len0_bad", 16'd0, 1);
    rearm("rearm_len0_bad");

    w = 32'hCAFE1234;
    exp_q.push_back({AW'(0), w});
    send_byte(8'h02);
    send_byte(8'h00);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    idle(3);
    chk("midload_writes", exp_q.size(), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midload_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    load("after_reset", 16'd3, -1);
    rearm("rearm_after_reset");

    load("full_capacity", 16'(1 << AW), -1);
    rearm("rearm_full");

    gaps = 1'b1;
    for (int f = 0; f < 8; f++) begin
      int n;
      int cs;
      n = $urandom_range(1, 8);
      cs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1;
      load($sformatf("rand%0d", f), 16'(n), cs);
      rearm($sformatf("rearm_rand%0d", f));
    end

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
